gcd_request_arbiter: RTL and testbench

//  Shares one GCD datapath/controller core between N requesters. Round-robin

---
 rtl/gcd_request_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_gcd_request_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_request_arbiter
// Brief    : Round-robin front end sharing one serial-load GCD core among N
//            requesters, with a local zero-operand path and a WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_request_arbiter #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_gcd,
    output logic                 rsp_err,
    output logic                 gcd_start,
    output logic [W-1:0]         gcd_data_in,
    input  logic                 gcd_done,
    input  logic [W-1:0]         gcd_result,
    output logic                 busy
);

    localparam int IDW   = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [IDW-1:0]   c_id_max   = IDW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_err;
    logic [CNT_W-1:0] r_wd_cnt;

    logic [W-1:0]     w_a_arr [N];
    logic [W-1:0]     w_b_arr [N];
    logic [IDW-1:0]   w_grant_id;
    logic             w_any_valid;
    logic [W-1:0]     w_a_sel;
    logic [W-1:0]     w_b_sel;
    logic             w_zero_op;
    logic             w_timeout;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*W +: W];
            assign w_b_arr[gi] = req_b[gi*W +: W];
        end
    endgenerate

    // First valid requester at or after the pointer, scanning with wrap.
    always_comb begin
        int             v_idx;
        logic [IDW-1:0] v_id;
        w_grant_id  = r_rr_ptr;
        w_any_valid = 1'b0;
        v_idx       = 0;
        v_id        = '0;
        for (int k = 0; k < N; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            v_id = IDW'(v_idx);
            if (!w_any_valid && req_valid[v_id]) begin
                w_any_valid = 1'b1;
                w_grant_id  = v_id;
            end
        end
    end

    assign w_a_sel   = w_a_arr[w_grant_id];
    assign w_b_sel   = w_b_arr[w_grant_id];
    assign w_zero_op = (w_a_sel == '0) || (w_b_sel == '0);
    assign w_timeout = (r_wd_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        gcd_start   = 1'b0;
        gcd_data_in = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid && rst_n) begin
                    req_ready[w_grant_id] = 1'b1;
                    w_state_nxt = w_zero_op ? S_RESP : S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                gcd_start   = 1'b1;
                gcd_data_in = r_a;
                w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                gcd_start   = 1'b1;
                gcd_data_in = r_b;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (gcd_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_wd_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_a      <= w_a_sel;
                        r_b      <= w_b_sel;
                        r_id     <= w_grant_id;
                        r_rr_ptr <= (w_grant_id == c_id_max) ? '0 : w_grant_id + 1'b1;
                        // gcd(x,0)=x and gcd(0,0)=0 both reduce to A|B.
                        if (w_zero_op) begin
                            r_result <= w_a_sel | w_b_sel;
                        end
                    end
                end
                S_LOAD_B: begin
                    r_wd_cnt <= '0;
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        r_result <= gcd_result;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_gcd   = r_result;
    assign rsp_err   = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gcd_request_arbiter.sv
`default_nettype none
// Directed self-checking bench for gcd_request_arbiter; the bench plays the GCD core.
module tb_gcd_request_arbiter;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 15;
    localparam int IDW     = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_gcd;
    logic           rsp_err;
    logic           gcd_start;
    logic [W-1:0]   gcd_data_in;
    logic           gcd_done;
    logic [W-1:0]   gcd_result;
    logic           busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcd_request_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
        .gcd_start(gcd_start), .gcd_data_in(gcd_data_in),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; gcd_done = 1'b0; gcd_result = '0;
        #2;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (rsp_gcd !== 16'd0) begin n_fail++; $display("FAIL reset_rsp_gcd: got %0d want 0", rsp_gcd); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_cmp++; if (gcd_start !== 1'b0) begin n_fail++; $display("FAIL reset_gcd_start: got %b want 0", gcd_start); end
        n_cmp++; if (gcd_data_in !== 16'd0) begin n_fail++; $display("FAIL reset_gcd_data_in: got %0d want 0", gcd_data_in); end
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 16'd65, 16'd39);
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if ({gcd_start, gcd_data_in} !== {1'b1, 16'd65}) begin n_fail++; $display("FAIL single_load_a: start=%b data=%0d want 1/65", gcd_start, gcd_data_in); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_busy: got %b want 0000", req_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if ({gcd_start, gcd_data_in} !== {1'b1, 16'd39}) begin n_fail++; $display("FAIL single_load_b: start=%b data=%0d want 1/39", gcd_start, gcd_data_in); end
        tick();
        @(negedge clk);
        n_cmp++; if ({busy, gcd_start, gcd_data_in} !== {1'b1, 1'b0, 16'd0}) begin n_fail++; $display("FAIL single_wait: busy=%b start=%b data=%0d want 1/0/0", busy, gcd_start, gcd_data_in); end
        tick();
        tick();
        gcd_done = 1'b1; gcd_result = 16'd13;
        tick();
        gcd_done = 1'b0; gcd_result = '0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd, rsp_err} !== {1'b1, 2'd0, 16'd13, 1'b0}) begin n_fail++; $display("FAIL single_rsp: valid=%b id=%0d gcd=%0d err=%b want 1/0/13/0", rsp_valid, rsp_id, rsp_gcd, rsp_err); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: valid=%b busy=%b want 0/0", rsp_valid, busy); end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_id;
        int guard;
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'd0, W'(i + 5));
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_id = t % N;
            exp_oh = 4'b0001 << exp_id;
            guard = 0;
            @(negedge clk);
            while (req_ready === 4'b0000 && guard < 10) begin
                tick();
                @(negedge clk);
                guard++;
            end
            n_cmp++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, exp_oh); end
            tick();
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd} !== {1'b1, IDW'(exp_id), W'(exp_id + 5)}) begin n_fail++; $display("FAIL rr_rsp%0d: valid=%b id=%0d gcd=%0d want 1/%0d/%0d", t, rsp_valid, rsp_id, rsp_gcd, exp_id, exp_id + 5); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_zero_operand();
        int           ids  [3];
        logic [W-1:0] as_v [3];
        logic [W-1:0] bs_v [3];
        logic [W-1:0] ex_v [3];
        logic [N-1:0] exp_oh;
        ids  = '{2, 2, 1};
        as_v = '{16'd0, 16'd0, 16'd27};
        bs_v = '{16'd48, 16'd0, 16'd0};
        ex_v = '{16'd48, 16'd0, 16'd27};
        for (int t = 0; t < 3; t++) begin
            set_req(ids[t], as_v[t], bs_v[t]);
            exp_oh = 4'b0001 << ids[t];
            req_valid = exp_oh;
            @(negedge clk);
            n_cmp++; if ({req_ready, gcd_start} !== {exp_oh, 1'b0}) begin n_fail++; $display("FAIL zero_grant%0d: ready=%b start=%b want %b/0", t, req_ready, gcd_start, exp_oh); end
            tick();
            req_valid = '0;
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd, gcd_start} !== {1'b1, IDW'(ids[t]), ex_v[t], 1'b0}) begin n_fail++; $display("FAIL zero_rsp%0d: valid=%b id=%0d gcd=%0d start=%b want 1/%0d/%0d/0", t, rsp_valid, rsp_id, rsp_gcd, gcd_start, ids[t], ex_v[t]); end
            tick();
        end
    endtask

    task automatic test_watchdog();
        int   wait_cnt;
        logic got;
        set_req(3, 16'd20, 16'd8);
        req_valid = 4'b1000;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wd_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        wait_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1 && gcd_start === 1'b0) wait_cnt++;
                tick();
            end
        end
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL wd_no_response: rsp_valid never rose within 60 cycles"); end
        n_cmp++; if (wait_cnt != TIMEOUT) begin n_fail++; $display("FAIL wd_wait_cycles: got %0d want %0d", wait_cnt, TIMEOUT); end
        n_cmp++; if ({rsp_err, rsp_gcd, rsp_id} !== {1'b1, 16'd0, 2'd3}) begin n_fail++; $display("FAIL wd_rsp: err=%b gcd=%0d id=%0d want 1/0/3", rsp_err, rsp_gcd, rsp_id); end
        tick();
        set_req(0, 16'd12, 16'd18);
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wd_next_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        gcd_done = 1'b1; gcd_result = 16'd6;
        tick();
        gcd_done = 1'b0; gcd_result = '0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_err, rsp_gcd, rsp_id} !== {1'b1, 1'b0, 16'd6, 2'd0}) begin n_fail++; $display("FAIL wd_next_rsp: valid=%b err=%b gcd=%0d id=%0d want 1/0/6/0", rsp_valid, rsp_err, rsp_gcd, rsp_id); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [23:0] hold_exp;
        hold_exp = {1'b1, 2'd1, 16'd9, 1'b0, 4'b0000};
        rsp_ready = 1'b0;
        set_req(1, 16'd0, 16'd9);
        set_req(2, 16'd0, 16'd4);
        req_valid = 4'b0110;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd, rsp_err, req_ready} !== hold_exp) begin n_fail++; $display("FAIL bp_hold%0d: valid=%b id=%0d gcd=%0d err=%b ready=%b want 1/1/9/0/0000", c, rsp_valid, rsp_id, rsp_gcd, rsp_err, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin n_fail++; $display("FAIL bp_handshake: valid=%b ready=%b want 1/0000", rsp_valid, req_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0100}) begin n_fail++; $display("FAIL bp_next_grant: valid=%b ready=%b want 0/0100", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd} !== {1'b1, 2'd2, 16'd4}) begin n_fail++; $display("FAIL bp_next_rsp: valid=%b id=%0d gcd=%0d want 1/2/4", rsp_valid, rsp_id, rsp_gcd); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 16'd10, 16'd4);
        req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if ({busy, gcd_start} !== 2'b10) begin n_fail++; $display("FAIL rm_in_wait: busy=%b start=%b want 1/0", busy, gcd_start); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, rsp_valid, rsp_err, gcd_start, gcd_data_in, rsp_id} !== {4'b0000, 16'd0, 2'd0}) begin n_fail++; $display("FAIL rm_async_clear: busy=%b valid=%b err=%b start=%b data=%0d id=%0d want all 0", busy, rsp_valid, rsp_err, gcd_start, gcd_data_in, rsp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        gcd_done = 1'b1; gcd_result = 16'd99;
        @(negedge clk);
        n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_stale_done0: busy=%b valid=%b want 0/0", busy, rsp_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_stale_done1: busy=%b valid=%b want 0/0", busy, rsp_valid); end
        tick();
        gcd_done = 1'b0; gcd_result = '0;
        for (int i = 0; i < N; i++) set_req(i, 16'd0, W'(i + 1));
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr_reset: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_gcd} !== {1'b1, 2'd0, 16'd1}) begin n_fail++; $display("FAIL rm_after_rsp: valid=%b id=%0d gcd=%0d want 1/0/1", rsp_valid, rsp_id, rsp_gcd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_operand();
        test_watchdog();
        test_back_pressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
